// File: rtl/sync_event_arbiter_pkg.sv
// sync_arb_pkg: shared FSM state encoding and width helper for the event arbiter
package sync_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        SETTLE = 2'd2,
        WAIT   = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_event_arbiter_rr_pick.sv
// rr_pick: round-robin search of pending bits starting at ptr, wrapping at NREQ
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [NREQ-1:0] winOh,
    output logic [IDW-1:0]  winIdx
);

    always_comb begin
        int j;
        valid  = 1'b0;
        winOh  = '0;
        winIdx = '0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j -= NREQ;
            if (!valid && pending[j]) begin
                valid     = 1'b1;
                winOh[j]  = 1'b1;
                winIdx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/sync_event_arbiter.sv
// sync_event_arbiter: funnels NREQ source-domain events through one toggle
// handshake synchronizer, round-robin, holding the winner ID until sRDY returns.
module sync_event_arbiter
    import sync_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            enable,
    input  logic [NREQ-1:0] req,
    input  logic            hs_rdy,
    output logic            hs_en,
    output logic [IDW-1:0]  xfer_id,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] pending,
    output logic [NREQ-1:0] coalesce,
    output logic            busy
);

    if (IDW != clog2(NREQ)) begin : gBadIdw
        $error("IDW must equal clog2(NREQ)");
    end

    state_t          state, stateNxt;
    logic [IDW-1:0]  ptr;
    logic            pickValid;
    logic [NREQ-1:0] pickOh;
    logic [IDW-1:0]  pickIdx;
    logic            issue;
    logic [NREQ-1:0] clr;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) uPick (
        .pending(pending),
        .ptr    (ptr),
        .valid  (pickValid),
        .winOh  (pickOh),
        .winIdx (pickIdx)
    );

    // SETTLE ignores hs_rdy for one cycle so a registered sRDY path cannot
    // report the previous transfer's ready as this one's completion.
    always_comb begin
        stateNxt = state;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                issue    = enable & hs_rdy & pickValid;
                stateNxt = issue ? FIRE : IDLE;
            end
            FIRE:    stateNxt = SETTLE;
            SETTLE:  stateNxt = WAIT;
            WAIT:    stateNxt = hs_rdy ? IDLE : WAIT;
            default: stateNxt = IDLE;
        endcase
    end

    assign clr  = issue ? pickOh : '0;
    assign busy = state != IDLE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= stateNxt;
    end

    // a request on the granting edge re-arms pending (set beats clear)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hs_en    <= 1'b0;
            grant    <= '0;
            pending  <= '0;
            coalesce <= '0;
            xfer_id  <= '0;
            ptr      <= '0;
        end else begin
            hs_en    <= issue;
            grant    <= clr;
            pending  <= (pending & ~clr) | req;
            coalesce <= req & pending & ~clr;
            if (issue) begin
                xfer_id <= pickIdx;
                ptr     <= (pickIdx == IDW'(NREQ - 1)) ? '0 : pickIdx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_event_arbiter.sv
// tb_sync_event_arbiter: table vectors, directed corner sequences and random
// traffic checked against a transfer-level reference model.
module tb_sync_event_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            enable = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            hs_rdy = 1'b0;
    logic            hs_en;
    logic [IDW-1:0]  xfer_id;
    logic [NREQ-1:0] grant, pending, coalesce;
    logic            busy;

    sync_event_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .req(req), .hs_rdy(hs_rdy),
        .hs_en(hs_en), .xfer_id(xfer_id), .grant(grant), .pending(pending),
        .coalesce(coalesce), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int nHs = 0;
    int rdyCnt = 0;
    int rdyLat = 6;
    bit autoRdy = 0;
    bit randLat = 0;
    int order[$];

    logic [NREQ-1:0] mPend, mGrant, mCoal;
    logic            mHsEn;
    logic [IDW-1:0]  mId;
    int              mPtr, mAge;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mPend = '0; mGrant = '0; mCoal = '0; mHsEn = 1'b0; mId = '0;
        mPtr = 0; mAge = -1;
    endtask

    // mAge: -1 idle, 0 enable cycle, 1 settle cycle, >=2 awaiting ready
    task automatic model_edge();
        int w;
        logic iss;
        logic [NREQ-1:0] clr;
        iss = (mAge < 0) && enable && hs_rdy && (mPend != 0);
        w = 0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (mPend[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
        clr = iss ? NREQ'(1 << w) : '0;
        mCoal = req & mPend & ~clr;
        mPend = (mPend & ~clr) | req;
        mHsEn = iss;
        mGrant = clr;
        if (iss) begin
            mId = IDW'(w);
            mPtr = (w + 1) % NREQ;
        end
        mAge = iss ? 0 : (mAge < 0) ? -1 : (mAge < 2) ? mAge + 1 : hs_rdy ? -1 : mAge;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("hs_en", hs_en, mHsEn);
        chk("grant", grant, mGrant);
        chk("pending", pending, mPend);
        chk("coalesce", coalesce, mCoal);
        chk("xfer_id", xfer_id, mId);
        chk("busy", busy, mAge >= 0);
        if (hs_en) begin
            nHs++;
            order.push_back(int'(xfer_id));
        end
        if (autoRdy) begin
            if (hs_en) begin
                hs_rdy = 1'b0;
                rdyCnt = randLat ? $urandom_range(1, 8) : rdyLat;
            end else if (rdyCnt > 0) begin
                rdyCnt--;
                if (rdyCnt == 0) hs_rdy = 1'b1;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_hs(input string nm, input int lim);
        int n0;
        n0 = nHs;
        for (int i = 0; i < lim && nHs == n0; i++) step();
        chk(nm, nHs - n0, 1);
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic       en;
        logic       rdy;
        logic       hsEn;
        logic [3:0] grant;
        logic [3:0] pend;
        logic [3:0] coal;
        logic       busy;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n0;
        logic [NREQ-1:0] rem;
        tbl[0] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2};
        tbl[2] = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd2};
        tbl[3] = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b1, 2'd2};
        tbl[4] = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b1, 2'd2};
        tbl[5] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd2};
        tbl[6] = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1};
        tbl[7] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
        tbl[8] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
        tbl[9] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1};

        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hs_en", hs_en, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer_id", xfer_id, 0);
        RST_N = 1'b1;

        // single event, coalesce twice, hs_rdy high during SETTLE
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; enable = tbl[i].en; hs_rdy = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_hs_en", i), hs_en, tbl[i].hsEn);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_coalesce", i), coalesce, tbl[i].coal);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_xfer_id", i), xfer_id, tbl[i].id);
        end
        req = '0;

        // reset in WAIT
        autoRdy = 1; rdyLat = 6; hs_rdy = 1'b1;
        req = 4'b1100; step(); req = '0;
        wait_hs("midrst_issue", 10);
        steps(3);
        chk("midrst_pre_busy", busy, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_hs_en", hs_en, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_coalesce", coalesce, 0);
        chk("midrst_xfer_id", xfer_id, 0);
        chk("midrst_busy", busy, 0);
        model_reset();
        rdyCnt = 0; hs_rdy = 1'b1;
        #2 RST_N = 1'b1;
        n0 = nHs;
        steps(10);
        chk("postrst_no_hs", nHs - n0, 0);

        // round robin from ptr 0
        order.delete();
        req = 4'b1111; step(); req = '0;
        steps(60);
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order.size() > i ? order[i] : -1, i);
        order.delete();
        req = 4'b1001; step(); req = '0;
        steps(40);
        chk("rr2_count", order.size(), 2);
        chk("rr2_first", order.size() > 0 ? order[0] : -1, 0);
        chk("rr2_second", order.size() > 1 ? order[1] : -1, 3);

        // request on the granting edge
        steps(20);
        req = 4'b0010; step();
        n0 = nHs;
        step(); req = '0;
        chk("race_grant", grant, 4'b0010);
        chk("race_pending1", pending[1], 1);
        chk("race_coalesce1", coalesce[1], 0);
        steps(30);
        chk("race_two_xfers", nHs - n0, 2);

        // not ready for 20 cycles
        steps(10);
        autoRdy = 0; hs_rdy = 1'b0;
        req = 4'b0010; step(); req = '0;
        n0 = nHs;
        steps(20);
        chk("notrdy_no_hs", nHs - n0, 0);
        hs_rdy = 1'b1; autoRdy = 1;
        wait_hs("notrdy_late_hs", 2);

        // enable dropped during WAIT
        steps(20);
        req = 4'b0011; step(); req = '0;
        wait_hs("en_first", 10);
        rem = 4'b0011 & ~grant;
        steps(2);
        enable = 1'b0;
        n0 = nHs;
        steps(40);
        chk("en_gated", nHs - n0, 0);
        chk("en_busy_done", busy, 0);
        chk("en_pending_kept", pending, rem);
        enable = 1'b1;
        wait_hs("en_resume", 10);
        chk("en_resume_grant", grant, rem);

        // random traffic
        randLat = 1;
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            enable = $urandom_range(0, 9) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
